// File: rtl/downcounter_16.sv
`default_nettype none
// ============================================================================
// Module   : downcounter_16
// Brief    : UART baud-rate generator with a 16x receive strobe and a 1x transmit strobe
// Revision : 1.0 - initial release
// ============================================================================
module downcounter_16 #(
  parameter int WIDTH      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] in,
  output logic             r_enable,
  output logic             t_enable
);

  localparam int                 c_SUB_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [c_SUB_W-1:0] c_SUB_MAX = c_SUB_W'(OVERSAMPLE - 1);

  logic [WIDTH-1:0]   r_div_q;
  logic [WIDTH-1:0]   r_cnt;
  logic [c_SUB_W-1:0] r_sub;
  logic               r_run;

  // A write always wins so that a reload restarts both phases on its own edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_q  <= '0;
      r_cnt    <= '0;
      r_sub    <= '0;
      r_run    <= 1'b0;
      r_enable <= 1'b0;
      t_enable <= 1'b0;
    end else if (wr_en) begin
      r_div_q  <= in;
      r_cnt    <= in;
      r_sub    <= '0;
      r_run    <= 1'b1;
      r_enable <= 1'b0;
      t_enable <= 1'b0;
    end else if (r_run) begin
      if (r_cnt != '0) begin
        r_cnt    <= r_cnt - 1'b1;
        r_enable <= 1'b0;
        t_enable <= 1'b0;
      end else begin
        r_cnt    <= r_div_q;
        r_sub    <= r_sub + 1'b1;
        r_enable <= 1'b1;
        t_enable <= (r_sub == c_SUB_MAX);
      end
    end else begin
      r_enable <= 1'b0;
      t_enable <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_downcounter_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_downcounter_16
// Brief    : Scoreboard bench for downcounter_16 against a pulse-count reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_downcounter_16;

  localparam int c_OVS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] din = '0;
  logic        r_enable;
  logic        t_enable;

  typedef struct packed { logic r; logic t; } exp_t;
  exp_t q[$];

  int checks   = 0;
  int failures = 0;

  // Reference: position since the load edge decides everything.
  bit     m_run = 1'b0;
  int     m_div = 0;
  longint m_k   = 0;

  downcounter_16 #(.WIDTH(16), .OVERSAMPLE(c_OVS)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .in       (din),
    .r_enable (r_enable),
    .t_enable (t_enable)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got r/t=%b required r/t=%b", name, $time, act, exp);
    end
  endfunction

  task automatic cycle(input logic rst_v, input logic wr_v, input logic [15:0] in_val);
    exp_t e;
    @(negedge clk);
    rst   = rst_v;
    wr_en = wr_v;
    din   = in_val;
    e = '0;
    if (!rst_v) begin
      m_run = 1'b0;
    end else if (wr_v) begin
      m_run = 1'b1;
      m_div = int'(in_val);
      m_k   = 0;
    end else if (m_run) begin
      m_k++;
      if (m_k % (m_div + 1) == 0) begin
        e.r = 1'b1;
        e.t = ((m_k / (m_div + 1)) % c_OVS) == 0;
      end
    end
    q.push_back(e);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic load(input logic [15:0] d);
    cycle(1'b1, 1'b1, d);
  endtask

  // Monitor: compares every registered output sample against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("strobes", {r_enable, t_enable}, {e.r, e.t});
      end
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    // Held in reset, then released with no write.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'($urandom));
    run_idle(50);

    // Divisor 15: two full transmit periods.
    load(16'h000F);
    run_idle(600);

    // Divisor 0: receive strobe every clock.
    load(16'h0000);
    run_idle(50);

    // Reload mid-period aborts the old phase.
    load(16'h000F);
    run_idle(37);
    load(16'h0003);
    run_idle(140);

    // Asynchronous reset between edges while strobing.
    load(16'h0000);
    run_idle(10);
    @(posedge clk);
    #2;
    rst   = 1'b0;
    m_run = 1'b0;
    #1;
    chk("async_clear", {r_enable, t_enable}, 2'b00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'($urandom));
    run_idle(40);

    // Largest divisor: no early strobe.
    load(16'hFFFF);
    run_idle(300);

    // Randomized divisors, run lengths and occasional mid-period reloads.
    for (int s = 0; s < 10; s++) begin
      d = int'($urandom_range(0, 12));
      load(16'(d));
      run_idle(int'($urandom_range(20, 16 * (d + 1) + 40)));
    end

    run_idle(5);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
